ram16_mem_ctrl: RTL and testbench
=================================

Name: ram16_mem_ctrl

Overview:
- Request/acknowledge front-end that sits directly upstream of the 16-bit byte-addressed RAM (ram16) and drives its addr/data_in/write_rq/output_en pins.
- The RAM only writes full 16-bit words (bytes addr and addr+1) and returns read data one clock after output_en. This block adds 8-bit stores by read-modify-write, and 8/16-bit loads with a single-cycle ready pulse for the CPU/bus side.

Parameters:
- addrSize, 9, byte-address width; must equal the addrSize of the attached ram16.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load; latched with req.
- size  in  1  0 = byte, 1 = 16-bit word; latched with req.
- addr  in  addrSize  byte address; latched with req; no alignment requirement.
- wdata  in  16  store data; byte stores use wdata[7:0]; latched with req.
- rdata  out  16  load result; byte loads zero-extended; held until the next load completes.
- ready  out  1  one-cycle pulse when the transaction is complete.
- busy  out  1  high whenever the state is not IDLE.
- ram_addr  out  addrSize  to ram16 addr.
- ram_data_in  out  16  to ram16 data_in.
- ram_write_rq  out  1  to ram16 write_rq.
- ram_output_en  out  1  to ram16 output_en.
- ram_data_out  in  16  from ram16 data_out.

Behaviour:
- Reset (asynchronous, immediate):
  - State is IDLE.
  - rdata, ram_addr, ram_data_in, internal latches = 0.
  - ready, busy, ram_write_rq, ram_output_en = 0.
  - ram_write_rq drops asynchronously, so reset mid-transaction never produces a partial or late write.
- States: IDLE, READ, CAPTURE, WRITE, ACK.
  - All RAM-side outputs and ready are decoded from registered state and latches only; there are no combinational paths from the req-side inputs.
- IDLE:
  - If req=1: latch addr/we/size/wdata; ram_addr <= addr.
  - Next state is WRITE if we=1 and size=1, otherwise READ.
  - If req=0: stay in IDLE.
- READ: ram_output_en=1 for exactly one cycle -> CAPTURE.
- CAPTURE: ram_data_out is valid this cycle; ram_output_en=0.
  - Load: rdata <= size ? ram_data_out : {8'h00, ram_data_out[7:0]} -> ACK.
  - Byte store: ram_data_in <= {ram_data_out[15:8], wdata_q[7:0]} -> WRITE.
- WRITE: ram_write_rq=1 for exactly one cycle.
  - For a word store, ram_data_in = wdata_q (loaded on IDLE exit).
  - Next state is ACK.
- ACK: ready=1 for one cycle -> IDLE unconditionally. req in ACK is ignored.
- Latency, counted from the req-sampling edge to the cycle ready is high:
  - word store 2 cycles
  - load (byte or word) 3 cycles
  - byte store 4 cycles
- Throughput: one transaction per latency+1 cycles. A req held high is re-taken in the IDLE cycle after ACK as a new transaction; the requester must drop req after ready.
- Inputs: changes on addr/wdata/we/size while busy=1 have no effect.
- rdata: unchanged by stores.
- ram_output_en and ram_write_rq are never high in the same cycle.
- Address wrap: a word or byte access at address 2**addrSize-1 wraps the upper byte to address 0 in the RAM. The block passes the address unmodified and does no range checking.
- Byte store preserves byte addr+1; it is rewritten with its previously read value.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, READ=1, CAPTURE=2, WRITE=3, ACK=4; 3-bit)
  - size encoding (SIZE_BYTE=0, SIZE_WORD=1)
- No sub-module. The byte merge is a single inline expression. The testbench instantiates ram16 as the downstream model.

Test Plan:
- Word store then load: store addr=0x010 wdata=0xBEEF, then load word 0x010.
  - Store: ready 2 cycles after req.
  - Load: ready 3 cycles after req; rdata=0xBEEF.
- Byte store merge: word store 0x020=0x1234, then byte store 0x020 wdata=0x00AB, then word load 0x020.
  - rdata=0x12AB; byte store ready 4 cycles after req; ram_write_rq high for exactly one cycle.
- Byte load zero-extension: word store 0x030=0xCAFE, then byte load 0x031 -> rdata=0x00CA.
  - Following a word store to 0x040, rdata must remain 0x00CA.
- Top-address wrap (addrSize=9): word store 0x1FF=0xA55A, then byte loads.
  - Byte load 0x1FF -> 0x005A; byte load 0x000 -> 0x00A5.
- Held req / ignored inputs: keep req=1 and toggle addr during busy.
  - Only the IDLE-sampled values are used; back-to-back transactions are separated by exactly one IDLE cycle.
- Reset mid-transaction: assert reset during the WRITE state of a byte store to 0x050 (pre-value 0x7777).
  - All outputs go to 0 immediately.
  - After release, word load 0x050 returns either 0x7777 or the fully merged value, never a partial value; busy=0 right after reset.

Source files
------------

// File: rtl/ram16_mem_ctrl_pkg.sv
// Shared encodings for the ram16 request/acknowledge front-end.
package ram16_mem_ctrl_pkg;

  // Controller states; the numeric values are fixed so that external
  // observers (debug taps, checkers) can decode them directly.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  // Access size as carried on the size request pin.
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/ram16_mem_ctrl.sv
// Front-end for the 16-bit byte-addressed ram16.
// Adds byte stores (read-modify-write of the containing word) and 8/16-bit
// loads with a one-cycle ready pulse. Every RAM-side output and ready is a
// register, so nothing on the request side reaches the RAM combinationally.
module ram16_mem_ctrl
  import ram16_mem_ctrl_pkg::*;
#(
  parameter int addrSize = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic                size,
  input  logic [addrSize-1:0] addr,
  input  logic [15:0]         wdata,
  output logic [15:0]         rdata,
  output logic                ready,
  output logic                busy,
  output logic [addrSize-1:0] ram_addr,
  output logic [15:0]         ram_data_in,
  output logic                ram_write_rq,
  output logic                ram_output_en,
  input  logic [15:0]         ram_data_out
);

  state_t     state;
  logic       we_q;
  logic       size_q;
  // Only the low byte of the store data is needed after IDLE: word stores
  // load ram_data_in directly when the request is taken.
  logic [7:0] byte_q;

  // Transaction sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      size_q        <= SIZE_BYTE;
      byte_q        <= 8'h00;
      rdata         <= 16'h0000;
      ready         <= 1'b0;
      busy          <= 1'b0;
      ram_addr      <= '0;
      ram_data_in   <= 16'h0000;
      ram_write_rq  <= 1'b0;
      ram_output_en <= 1'b0;
    end else begin
      // Strobes default low so each is high for exactly one cycle.
      ready         <= 1'b0;
      ram_write_rq  <= 1'b0;
      ram_output_en <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q     <= we;
            size_q   <= size;
            byte_q   <= wdata[7:0];
            ram_addr <= addr;
            busy     <= 1'b1;
            if (we && (size == SIZE_WORD)) begin
              // Full-word store needs no read: go straight to the write.
              ram_data_in  <= wdata;
              ram_write_rq <= 1'b1;
              state        <= ST_WRITE;
            end else begin
              // Loads and byte stores both start by reading the word.
              ram_output_en <= 1'b1;
              state         <= ST_READ;
            end
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_READ: begin
          // RAM registers its output on this edge; data is valid next cycle.
          busy  <= 1'b1;
          state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          busy <= 1'b1;
          if (!we_q) begin
            rdata <= (size_q == SIZE_WORD) ? ram_data_out
                                           : {8'h00, ram_data_out[7:0]};
            ready <= 1'b1;
            state <= ST_ACK;
          end else begin
            // Byte store: keep byte addr+1 as read, replace byte addr.
            ram_data_in  <= {ram_data_out[15:8], byte_q};
            ram_write_rq <= 1'b1;
            state        <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          busy  <= 1'b1;
          ready <= 1'b1;
          state <= ST_ACK;
        end

        ST_ACK: begin
          // req is ignored here; a held req is re-taken from IDLE.
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram16_mem_ctrl.sv
// Bench for ram16_mem_ctrl with a behavioural ram16 attached downstream.
module tb_ram16_mem_ctrl;

  localparam int AW = 9;

  logic          clk;
  logic          reset;
  logic          req;
  logic          we;
  logic          size;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic          ready;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data_in;
  logic          ram_write_rq;
  logic          ram_output_en;
  logic [15:0]   ram_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected completion: latency (or absolute ready cycle) and accepted rdata.
  typedef struct {
    int          lat;
    logic [15:0] rdata;
    logic [15:0] alt;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  ref_mem [0:(1<<AW)-1];
  logic [15:0] last_rdata;

  int wr_pulses = 0;
  int both_cnt  = 0;

  ram16_mem_ctrl #(.addrSize(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .size         (size),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_write_rq (ram_write_rq),
    .ram_output_en(ram_output_en),
    .ram_data_out (ram_data_out)
  );

  // Behavioural ram16: word write of bytes addr/addr+1, read data one clock late.
  logic [7:0]    ram_mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_p1;
  assign ram_addr_p1 = ram_addr + 9'd1;

  always @(posedge clk) begin
    if (ram_write_rq) begin
      ram_mem[ram_addr]    <= ram_data_in[7:0];
      ram_mem[ram_addr_p1] <= ram_data_in[15:8];
    end
    if (ram_output_en) begin
      ram_data_out <= {ram_mem[ram_addr_p1], ram_mem[ram_addr]};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_write_rq) wr_pulses++;
    if (ram_write_rq && ram_output_en) both_cnt++;
  end

  // Build the expected result of one transaction from the reference memory.
  task automatic model_txn(input logic w, input logic s, input logic [AW-1:0] a,
                           input logic [15:0] d, output exp_t e);
    logic [AW-1:0] a1;
    a1 = a + 9'd1;
    if (!w) begin
      e.rdata    = s ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
      last_rdata = e.rdata;
    end else begin
      ref_mem[a] = d[7:0];
      if (s) ref_mem[a1] = d[15:8];
      e.rdata = last_rdata;
    end
    e.alt = e.rdata;
    e.lat = w ? (s ? 2 : 4) : 3;
  endtask

  // One complete transaction: push expectation, drive, pop and check on ready.
  task automatic txn(input logic w, input logic s, input logic [AW-1:0] a,
                     input logic [15:0] d, input string name);
    exp_t e;
    exp_t got_e;
    int   start_wr;
    int   seen;
    model_txn(w, s, a, d, e);
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; we = w; size = s; addr = a; wdata = d;
    start_wr = wr_pulses;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ready) begin
        seen = c;
        break;
      end
      @(posedge clk); #1;
    end
    got_e = sb.pop_front();
    n_checks++;
    if (seen == 0) begin
      n_fail++;
      $display("FAIL %s timeout: no ready within 10 cycles, required latency %0d", name, got_e.lat);
    end else begin
      if (seen != got_e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d required %0d", name, seen, got_e.lat);
      end
      n_checks++;
      if (rdata !== got_e.rdata && rdata !== got_e.alt) begin
        n_fail++;
        $display("FAIL %s rdata: got %h required %h", name, rdata, got_e.rdata);
      end
      n_checks++;
      if ((wr_pulses - start_wr) != (w ? 1 : 0)) begin
        n_fail++;
        $display("FAIL %s write pulses: got %0d required %0d", name, wr_pulses - start_wr, w ? 1 : 0);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle after ack: busy=%b ready=%b required 0 0", name, busy, ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 1'b0; addr = '0; wdata = 16'h0000;
    last_rdata = 16'h0000;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rdata, ram_addr, ram_data_in, ready, busy, ram_write_rq, ram_output_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdata=%h ram_addr=%h data_in=%h rdy=%b busy=%b wr=%b oe=%b required all 0",
               rdata, ram_addr, ram_data_in, ready, busy, ram_write_rq, ram_output_en);
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b ready=%b required 0 0", busy, ready);
    end
  endtask

  task automatic test_word_store_load();
    txn(1'b1, 1'b1, 9'h010, 16'hBEEF, "word_store_010");
    txn(1'b0, 1'b1, 9'h010, 16'h0000, "word_load_010");
    n_checks++;
    if (rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL word_load_const: got %h required BEEF", rdata);
    end
  endtask

  task automatic test_byte_merge();
    txn(1'b1, 1'b1, 9'h020, 16'h1234, "word_store_020");
    txn(1'b1, 1'b0, 9'h020, 16'h00AB, "byte_store_020");
    txn(1'b0, 1'b1, 9'h020, 16'h0000, "word_load_020");
    n_checks++;
    if (rdata !== 16'h12AB) begin
      n_fail++;
      $display("FAIL byte_merge_const: got %h required 12AB", rdata);
    end
  endtask

  task automatic test_byte_load();
    txn(1'b1, 1'b1, 9'h030, 16'hCAFE, "word_store_030");
    txn(1'b0, 1'b0, 9'h031, 16'h0000, "byte_load_031");
    n_checks++;
    if (rdata !== 16'h00CA) begin
      n_fail++;
      $display("FAIL byte_load_zext: got %h required 00CA", rdata);
    end
    txn(1'b1, 1'b1, 9'h040, 16'h5151, "word_store_040");
    n_checks++;
    if (rdata !== 16'h00CA) begin
      n_fail++;
      $display("FAIL rdata_hold_after_store: got %h required 00CA", rdata);
    end
  endtask

  task automatic test_wrap();
    txn(1'b1, 1'b1, 9'h1FF, 16'hA55A, "word_store_1ff");
    txn(1'b0, 1'b0, 9'h1FF, 16'h0000, "byte_load_1ff");
    n_checks++;
    if (rdata !== 16'h005A) begin
      n_fail++;
      $display("FAIL wrap_low: got %h required 005A", rdata);
    end
    txn(1'b0, 1'b0, 9'h000, 16'h0000, "byte_load_000");
    n_checks++;
    if (rdata !== 16'h00A5) begin
      n_fail++;
      $display("FAIL wrap_high: got %h required 00A5", rdata);
    end
    txn(1'b0, 1'b1, 9'h1FF, 16'h0000, "word_load_1ff");
  endtask

  // Held req with inputs scrambled while busy; second request taken in the one IDLE cycle.
  task automatic test_back_to_back();
    exp_t e;
    exp_t got_e;
    int   done;
    int   idle_cycles;
    model_txn(1'b0, 1'b1, 9'h010, 16'h0000, e);
    e.lat = 3;
    sb.push_back(e);
    model_txn(1'b0, 1'b0, 9'h020, 16'h0000, e);
    e.lat = 7;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 1'b1; addr = 9'h010; wdata = 16'h0000;
    done = 0;
    idle_cycles = 0;
    for (int c = 1; c <= 20 && done < 2; c++) begin
      @(posedge clk); #1;
      if (ready) begin
        got_e = sb.pop_front();
        n_checks++;
        if (c != got_e.lat) begin
          n_fail++;
          $display("FAIL b2b ready cycle: got %0d required %0d", c, got_e.lat);
        end
        n_checks++;
        if (rdata !== got_e.rdata) begin
          n_fail++;
          $display("FAIL b2b rdata: got %h required %h", rdata, got_e.rdata);
        end
        done++;
        if (done == 2) req = 1'b0;
      end
      @(negedge clk);
      if (busy) begin
        we = 1'b1; size = 1'b1; addr = 9'(c * 37); wdata = 16'hDEAD;
      end else begin
        idle_cycles++;
        we = 1'b0; size = 1'b0; addr = 9'h020; wdata = 16'h0000;
      end
    end
    n_checks++;
    if (done != 2) begin
      n_fail++;
      $display("FAIL b2b completions: got %0d required 2", done);
      sb.delete();
    end
    n_checks++;
    if (idle_cycles != 1) begin
      n_fail++;
      $display("FAIL b2b idle gap: got %0d required 1", idle_cycles);
    end
    req = 1'b0; we = 1'b0; size = 1'b0; addr = '0;
    repeat (2) @(posedge clk);
    txn(1'b0, 1'b1, 9'h020, 16'h0000, "b2b_no_corruption_020");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   seen;
    txn(1'b1, 1'b1, 9'h050, 16'h7777, "word_store_050");
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 1'b0; addr = 9'h050; wdata = 16'h00AB;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ram_write_rq) begin
        seen = c;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 3) begin
      n_fail++;
      $display("FAIL reset_mid write cycle: got %0d required 3", seen);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({rdata, ram_addr, ram_data_in, ready, busy, ram_write_rq, ram_output_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid immediate: rdata=%h ram_addr=%h data_in=%h rdy=%b busy=%b wr=%b oe=%b required all 0",
               rdata, ram_addr, ram_data_in, ready, busy, ram_write_rq, ram_output_en);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rdata = 16'h0000;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid busy after release: got %b required 0", busy);
    end
    // Either the old word or the fully merged word is acceptable, nothing else.
    ref_mem[9'h050] = 8'h77;
    ref_mem[9'h051] = 8'h77;
    model_txn(1'b0, 1'b1, 9'h050, 16'h0000, e);
    e.alt = 16'h77AB;
    sb.push_back(e);
    sb.pop_back();
    txn_either(e);
  endtask

  // Word load of 0x050 accepting either of two values.
  task automatic txn_either(input exp_t e);
    exp_t got_e;
    int   seen;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 1'b1; addr = 9'h050; wdata = 16'h0000;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ready) begin
        seen = c;
        break;
      end
      @(posedge clk); #1;
    end
    got_e = sb.pop_front();
    n_checks++;
    if (seen != 3) begin
      n_fail++;
      $display("FAIL reset_mid reload latency: got %0d required 3", seen);
    end
    n_checks++;
    if (rdata !== got_e.rdata && rdata !== got_e.alt) begin
      n_fail++;
      $display("FAIL reset_mid reload rdata: got %h required %h or %h", rdata, got_e.rdata, got_e.alt);
    end
  endtask

  task automatic test_strobe_exclusive();
    n_checks++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: got %0d cycles required 0", both_cnt);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_merge();
    test_byte_load();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_strobe_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
